convolution: RTL and testbench

CONVOLUTION -- requirements
Module: convolution

---
 rtl/conv_pkg.sv | 14 +
 rtl/conv_addr_gen.sv | 86 ++++++++
 rtl/kernels.sv | 41 ++++
 rtl/convolution.sv | 111 +++++++++++
 tb/tb_convolution.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared widths and FSM state encoding for the 3x3 convolution block.
package conv_pkg;
    localparam int PIX_W     = 12;
    localparam int COEF_W    = 8;
    localparam int ACC_W     = 26;
    localparam int SHIFT_MAX = 25;
    localparam int PIX_MAX   = (1 << PIX_W) - 1;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DRAIN,
        ST_WRITE
    } conv_state_e;
endpackage

// File: rtl/conv_addr_gen.sv
// Tap counter and raster position for the convolution scan; registers the BRAM address one cycle ahead.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int SW_WIRE_CNT = 16,
    parameter int RD_WIRE_CNT = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        fetch,
    input  logic                                        write,
    output logic [$clog2(SW_WIRE_CNT*RD_WIRE_CNT)-1:0]  bram_addr,
    output logic [$clog2(SW_WIRE_CNT):0]                col,
    output logic [$clog2(RD_WIRE_CNT):0]                row,
    output logic [1:0]                                  dx,
    output logic [1:0]                                  dy,
    output logic                                        tap_inb,
    output logic                                        tap_first,
    output logic                                        tap_last
);
    localparam int AW = $clog2(SW_WIRE_CNT*RD_WIRE_CNT);
    localparam int CW = $clog2(SW_WIRE_CNT) + 1;
    localparam int RW = $clog2(RD_WIRE_CNT) + 1;

    logic [1:0]    nxt_dx, nxt_dy;
    logic [CW-1:0] nxt_col;
    logic [RW-1:0] nxt_row;
    logic          nxt_fetch, nxt_inb;
    logic [AW-1:0] nxt_addr;
    int            tc, tr;

    assign tap_first = (dx == 2'd0) && (dy == 2'd0);
    assign tap_last  = (dx == 2'd2) && (dy == 2'd2);

    // Address is computed for the tap being entered so it is on the bus during that tap's cycle
    always_comb begin
        nxt_dx    = dx;
        nxt_dy    = dy;
        nxt_col   = col;
        nxt_row   = row;
        nxt_fetch = 1'b0;
        if (fetch && !tap_last) begin
            nxt_fetch = 1'b1;
            if (dx == 2'd2) begin
                nxt_dx = 2'd0;
                nxt_dy = dy + 2'd1;
            end else begin
                nxt_dx = dx + 2'd1;
            end
        end else if (write) begin
            nxt_fetch = 1'b1;
            nxt_dx    = 2'd0;
            nxt_dy    = 2'd0;
            if (int'(col) == SW_WIRE_CNT - 1) begin
                nxt_col = '0;
                nxt_row = (int'(row) == RD_WIRE_CNT - 1) ? '0 : row + RW'(1);
            end else begin
                nxt_col = col + CW'(1);
            end
        end
        tc       = int'(nxt_col) + int'(nxt_dx) - 1;
        tr       = int'(nxt_row) + int'(nxt_dy) - 1;
        nxt_inb  = nxt_fetch && (tc >= 0) && (tc < SW_WIRE_CNT) && (tr >= 0) && (tr < RD_WIRE_CNT);
        nxt_addr = AW'(tc + tr * SW_WIRE_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dx        <= '0;
            dy        <= '0;
            col       <= '0;
            row       <= '0;
            bram_addr <= '0;
            tap_inb   <= 1'b0;
        end else begin
            dx      <= nxt_dx;
            dy      <= nxt_dy;
            col     <= nxt_col;
            row     <= nxt_row;
            tap_inb <= nxt_inb;
            if (nxt_inb) begin
                bram_addr <= nxt_addr;
            end
        end
    end
endmodule

// File: rtl/kernels.sv
// Constant 3x3 kernel source: 0 identity, 1 box, 2 Gaussian, 3 Laplacian, others identity.
module kernels
    import conv_pkg::*;
#(
    parameter int K_SELECT = 0
) (
    input  logic                               rst_in,
    output logic signed [2:0][2:0][COEF_W-1:0] coeffs,
    output logic signed [COEF_W-1:0]           shift
);
    logic unused_rst;
    assign unused_rst = rst_in;

    // Concatenations list rows dy=2..0, each dx=2..0
    always_comb begin
        case (K_SELECT)
            1: begin
                coeffs = {9{8'sd1}};
                shift  = 8'sd3;
            end
            2: begin
                coeffs = {8'sd1, 8'sd2, 8'sd1,
                          8'sd2, 8'sd4, 8'sd2,
                          8'sd1, 8'sd2, 8'sd1};
                shift  = 8'sd4;
            end
            3: begin
                coeffs = {8'sd0,  8'shff, 8'sd0,
                          8'shff, 8'sd4,  8'shff,
                          8'sd0,  8'shff, 8'sd0};
                shift  = 8'sd0;
            end
            default: begin
                coeffs = {8'sd0, 8'sd0, 8'sd0,
                          8'sd0, 8'sd1, 8'sd0,
                          8'sd0, 8'sd0, 8'sd0};
                shift  = 8'sd0;
            end
        endcase
    end
endmodule

// File: rtl/convolution.sv
// 3x3 raster-scan convolution over an external BRAM, 11 cycles per output pixel.
// Define CONV_SATURATE_EN to clamp results to 0..4095 instead of wrapping to 12 bits.
module convolution
    import conv_pkg::*;
#(
    parameter int SW_WIRE_CNT = 16,
    parameter int RD_WIRE_CNT = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [PIX_W-1:0]                            data_in,
    input  logic signed [2:0][2:0][COEF_W-1:0]          coeffs,
    input  logic signed [COEF_W-1:0]                    shift,
    output logic [$clog2(SW_WIRE_CNT*RD_WIRE_CNT)-1:0]  bram_addr,
    output logic [$clog2(SW_WIRE_CNT):0]                sw_wires,
    output logic [$clog2(RD_WIRE_CNT):0]                rd_wires,
    output logic [PIX_W-1:0]                            data_out
);
    conv_state_e                        state;
    logic [$clog2(SW_WIRE_CNT):0]       col;
    logic [$clog2(RD_WIRE_CNT):0]       row;
    logic [1:0]                         dx, dy, p_dx, p_dy;
    logic                               tap_inb, tap_first, tap_last, p_valid;
    logic signed [2:0][2:0][COEF_W-1:0] coef_r;
    logic [4:0]                         sh_r;
    logic signed [COEF_W-1:0]           coef_sel;
    logic signed [ACC_W-1:0]            acc, prod;
    logic [PIX_W-1:0]                   pix;
`ifdef CONV_SATURATE_EN
    logic signed [ACC_W-1:0]            shifted;
`endif

    conv_addr_gen #(
        .SW_WIRE_CNT(SW_WIRE_CNT),
        .RD_WIRE_CNT(RD_WIRE_CNT)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .fetch     (state == ST_FETCH),
        .write     (state == ST_WRITE),
        .bram_addr (bram_addr),
        .col       (col),
        .row       (row),
        .dx        (dx),
        .dy        (dy),
        .tap_inb   (tap_inb),
        .tap_first (tap_first),
        .tap_last  (tap_last)
    );

    always_comb begin
        coef_sel = coef_r[p_dy][p_dx];
        prod     = ACC_W'($signed({1'b0, data_in})) * ACC_W'(coef_sel);
`ifdef CONV_SATURATE_EN
        shifted = acc >>> sh_r;
        if (shifted < 0) begin
            pix = '0;
        end else if (shifted > ACC_W'(PIX_MAX)) begin
            pix = '1;
        end else begin
            pix = shifted[PIX_W-1:0];
        end
`else
        pix = PIX_W'(acc >>> sh_r);
`endif
    end

    // data_in lags the address by one cycle, so each product is taken with the tap index of the previous cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FETCH;
            acc      <= '0;
            p_valid  <= 1'b0;
            p_dx     <= '0;
            p_dy     <= '0;
            coef_r   <= '0;
            sh_r     <= '0;
            data_out <= '0;
            sw_wires <= '0;
            rd_wires <= '0;
        end else begin
            p_valid <= (state == ST_FETCH) && tap_inb;
            p_dx    <= dx;
            p_dy    <= dy;
            if (state == ST_FETCH && tap_first) begin
                acc    <= '0;
                coef_r <= coeffs;
                if (shift < 0) begin
                    sh_r <= '0;
                end else if (shift > COEF_W'(SHIFT_MAX)) begin
                    sh_r <= 5'(SHIFT_MAX);
                end else begin
                    sh_r <= shift[4:0];
                end
            end else if (p_valid) begin
                acc <= acc + prod;
            end
            case (state)
                ST_FETCH: if (tap_last) state <= ST_DRAIN;
                ST_DRAIN: state <= ST_WRITE;
                ST_WRITE: begin
                    state    <= ST_FETCH;
                    data_out <= pix;
                    sw_wires <= col;
                    rd_wires <= row;
                end
                default:  state <= ST_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_convolution.sv
// Directed bench for convolution: per-kernel impulse frames, address sequence, coefficient sampling and reset.
module tb_convolution;
    import conv_pkg::*;

    localparam int SW = 16;
    localparam int RD = 16;
    localparam int NPIX = SW * RD;

    logic                               clk = 1'b0;
    logic                               rst;
    logic [11:0]                        data_in;
    logic signed [2:0][2:0][7:0]        coeffs;
    logic signed [7:0]                  shift;
    logic [7:0]                         bram_addr;
    logic [4:0]                         sw_wires, rd_wires;
    logic [11:0]                        data_out;

    logic signed [2:0][2:0][7:0]        kc [5];
    logic signed [7:0]                  ks [5];
    logic [2:0]                         kidx;
    logic                               sh_ovr_en;
    logic signed [7:0]                  sh_ovr;
    logic [11:0]                        mem [0:NPIX-1];
    int                                 out_img [0:RD-1][0:SW-1];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { int kx; int shv; int ic; int ir; int iv; int nz; } scen_t;
    typedef struct { int sc; int cc; int cr; int exp; } vec_t;
    typedef struct { int cyc; int addr; } avec_t;

    scen_t scn [11];
    vec_t  vecs [$];
    avec_t avec [$];

    always #5 clk = ~clk;

    kernels #(.K_SELECT(0)) u_k0 (.rst_in(rst), .coeffs(kc[0]), .shift(ks[0]));
    kernels #(.K_SELECT(1)) u_k1 (.rst_in(rst), .coeffs(kc[1]), .shift(ks[1]));
    kernels #(.K_SELECT(2)) u_k2 (.rst_in(rst), .coeffs(kc[2]), .shift(ks[2]));
    kernels #(.K_SELECT(3)) u_k3 (.rst_in(rst), .coeffs(kc[3]), .shift(ks[3]));
    kernels #(.K_SELECT(7)) u_k7 (.rst_in(rst), .coeffs(kc[4]), .shift(ks[4]));

    always_comb begin
        coeffs = kc[kidx];
        shift  = sh_ovr_en ? sh_ovr : ks[kidx];
    end

    always @(posedge clk) data_in <= mem[bram_addr];

    convolution #(
        .SW_WIRE_CNT(SW),
        .RD_WIRE_CNT(RD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .coeffs    (coeffs),
        .shift     (shift),
        .bram_addr (bram_addr),
        .sw_wires  (sw_wires),
        .rd_wires  (rd_wires),
        .data_out  (data_out)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_scen(input int s);
        kidx      = 3'(scn[s].kx);
        sh_ovr_en = (scn[s].shv != 999);
        sh_ovr    = 8'(scn[s].shv);
        for (int i = 0; i < NPIX; i++) mem[i] = '0;
        mem[8'(scn[s].ic + scn[s].ir * SW)] = 12'(scn[s].iv);
    endtask

    task automatic reset_release();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_frame(input int s);
        int order_err;
        int nz;
        set_scen(s);
        reset_release();
        order_err = 0;
        for (int p = 0; p < NPIX; p++) begin
            repeat (11) @(posedge clk);
            #1;
            if (int'(sw_wires) != p % SW || int'(rd_wires) != p / SW) order_err++;
            out_img[p / SW][p % SW] = int'(data_out);
        end
        chk($sformatf("scan order S%0d", s), order_err, 0);
        nz = 0;
        for (int r = 0; r < RD; r++)
            for (int c = 0; c < SW; c++)
                if (out_img[r][c] != 0) nz++;
        chk($sformatf("nonzero count S%0d", s), nz, scn[s].nz);
    endtask

    initial begin
        int cur;
        int ai;
        rst       = 1'b1;
        kidx      = '0;
        sh_ovr_en = 1'b0;
        sh_ovr    = '0;
        for (int i = 0; i < NPIX; i++) mem[i] = '0;

        // kx: 0 identity, 1 box, 2 Gaussian, 3 Laplacian, 4 = K_SELECT 7; shv 999 = kernel's own shift
        scn[0]  = '{0, 999, 7, 7, 4095, 1};
        scn[1]  = '{1, 999, 7, 7, 4095, 9};
        scn[2]  = '{1, 999, 0, 0, 4095, 4};
`ifdef CONV_SATURATE_EN
        scn[3]  = '{3, 999, 7, 7, 4095, 1};
`else
        scn[3]  = '{3, 999, 7, 7, 4095, 5};
`endif
        scn[4]  = '{2, 999, 7, 7, 4095, 9};
        scn[5]  = '{2, 999, 15, 15, 100, 4};
        scn[6]  = '{1, 999, 15, 0, 800, 4};
        scn[7]  = '{0, -3, 3, 4, 100, 1};
        scn[8]  = '{4, 999, 2, 2, 77, 1};
        scn[9]  = '{0, 999, 0, 0, 1000, 1};
        scn[10] = '{1, 999, 8, 8, 0, 0};

        vecs.push_back('{0, 7, 7, 4095});
        vecs.push_back('{0, 6, 7, 0});
        vecs.push_back('{0, 7, 8, 0});
        vecs.push_back('{1, 6, 6, 511});
        vecs.push_back('{1, 7, 7, 511});
        vecs.push_back('{1, 8, 8, 511});
        vecs.push_back('{1, 8, 6, 511});
        vecs.push_back('{1, 9, 7, 0});
        vecs.push_back('{1, 7, 5, 0});
        vecs.push_back('{2, 0, 0, 511});
        vecs.push_back('{2, 1, 0, 511});
        vecs.push_back('{2, 0, 1, 511});
        vecs.push_back('{2, 1, 1, 511});
        vecs.push_back('{2, 2, 0, 0});
        vecs.push_back('{2, 0, 2, 0});
        vecs.push_back('{2, 15, 15, 0});
`ifdef CONV_SATURATE_EN
        vecs.push_back('{3, 7, 7, 4095});
        vecs.push_back('{3, 6, 7, 0});
        vecs.push_back('{3, 8, 7, 0});
        vecs.push_back('{3, 7, 6, 0});
        vecs.push_back('{3, 7, 8, 0});
`else
        vecs.push_back('{3, 7, 7, 4092});
        vecs.push_back('{3, 6, 7, 1});
        vecs.push_back('{3, 8, 7, 1});
        vecs.push_back('{3, 7, 6, 1});
        vecs.push_back('{3, 7, 8, 1});
`endif
        vecs.push_back('{3, 6, 6, 0});
        vecs.push_back('{4, 7, 7, 1023});
        vecs.push_back('{4, 6, 7, 511});
        vecs.push_back('{4, 7, 8, 511});
        vecs.push_back('{4, 6, 6, 255});
        vecs.push_back('{4, 8, 8, 255});
        vecs.push_back('{4, 9, 9, 0});
        vecs.push_back('{5, 15, 15, 25});
        vecs.push_back('{5, 14, 15, 12});
        vecs.push_back('{5, 15, 14, 12});
        vecs.push_back('{5, 14, 14, 6});
        vecs.push_back('{5, 0, 0, 0});
        vecs.push_back('{6, 15, 0, 100});
        vecs.push_back('{6, 14, 1, 100});
        vecs.push_back('{6, 0, 0, 0});
        vecs.push_back('{6, 0, 1, 0});
        vecs.push_back('{7, 3, 4, 100});
        vecs.push_back('{8, 2, 2, 77});
        vecs.push_back('{8, 2, 3, 0});

        // Pixel (0,0) taps, start of pixel (1,0), then pixel (1,1) taps (pixel 17 starts at cycle 187)
        avec.push_back('{0, 0});
        avec.push_back('{1, 0});
        avec.push_back('{3, 0});
        avec.push_back('{4, 0});
        avec.push_back('{5, 1});
        avec.push_back('{6, 1});
        avec.push_back('{7, 16});
        avec.push_back('{8, 17});
        avec.push_back('{9, 17});
        avec.push_back('{10, 17});
        avec.push_back('{11, 17});
        avec.push_back('{14, 0});
        avec.push_back('{187, 0});
        avec.push_back('{188, 1});
        avec.push_back('{189, 2});
        avec.push_back('{190, 16});
        avec.push_back('{191, 17});
        avec.push_back('{192, 18});
        avec.push_back('{193, 32});
        avec.push_back('{194, 33});
        avec.push_back('{195, 34});

        cur = -1;
        foreach (vecs[i]) begin
            if (vecs[i].sc != cur) begin
                cur = vecs[i].sc;
                run_frame(cur);
            end
            chk($sformatf("pixel S%0d (%0d,%0d)", vecs[i].sc, vecs[i].cc, vecs[i].cr),
                out_img[vecs[i].cr][vecs[i].cc], vecs[i].exp);
        end

        // Address sequence after reset release
        set_scen(10);
        reset_release();
        ai = 0;
        for (int c = 0; c <= 195; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (ai < avec.size() && avec[ai].cyc == c) begin
                chk($sformatf("bram_addr cycle %0d", c), int'(bram_addr), avec[ai].addr);
                ai++;
            end
        end

        // Kernel switched mid-pixel only takes effect from the next pixel
        set_scen(9);
        reset_release();
        repeat (3) @(posedge clk);
        #1 kidx = 3'd1;
        repeat (8) @(posedge clk);
        #1;
        chk("coef sample pixel0", int'(data_out), 1000);
        repeat (11) @(posedge clk);
        #1;
        chk("coef sample pixel1 col", int'(sw_wires), 1);
        chk("coef sample pixel1", int'(data_out), 125);

        // Reset in the middle of pixel (5,3) of a uniform image
        set_scen(0);
        for (int i = 0; i < NPIX; i++) mem[i] = 12'd1000;
        reset_release();
        repeat (53 * 11) @(posedge clk);
        #1;
        chk("pre-reset sw", int'(sw_wires), 4);
        chk("pre-reset rd", int'(rd_wires), 3);
        chk("pre-reset data", int'(data_out), 1000);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("in-reset data", int'(data_out), 0);
        chk("in-reset sw", int'(sw_wires), 0);
        chk("in-reset rd", int'(rd_wires), 0);
        chk("in-reset addr", int'(bram_addr), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("post-reset cycle10 data", int'(data_out), 0);
        @(posedge clk);
        #1;
        chk("post-reset cycle11 data", int'(data_out), 1000);
        chk("post-reset cycle11 sw", int'(sw_wires), 0);
        chk("post-reset cycle11 rd", int'(rd_wires), 0);
        repeat (11) @(posedge clk);
        #1;
        chk("post-reset next sw", int'(sw_wires), 1);
        chk("post-reset next data", int'(data_out), 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
